// File: rtl/display_decoder_pkg.sv
// ----------------------------------------------------------------------------
// display_decoder_pkg
//   Shared definitions for the binary-to-decimal display stage: converter
//   state encoding, default width/digit constants and the active-low
//   seven-segment patterns (bit order g..a).
//   Optional build macro used by the consumers of this package:
//     DISPLAY_BLANK_EN - blank leading zero digits (digit 0 always shown).
// ----------------------------------------------------------------------------
package display_decoder_pkg;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/display_decoder_seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
//   Combinational BCD digit to active-low seven-segment pattern.
//   Ports:
//     digit   in  4  BCD digit (0-9; larger codes show blank)
//     pattern out 7  active-low segments, bit order g..a
// ----------------------------------------------------------------------------
module seg7_decode
    import display_decoder_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_decoder.sv
// ----------------------------------------------------------------------------
// display_decoder
//   Captures a 32-bit word, converts it to ten BCD digits with a serial
//   shift-add-3 (double-dabble) engine and drives ten active-low
//   seven-segment digits. A single pending buffer holds the most recent
//   word requested while a conversion is running, so the last word stored
//   is always the one finally displayed.
//   Ports:
//     clk   in   1   core clock, rising edge
//     rst   in   1   synchronous active-high reset
//     value in   32  unsigned word to display
//     load  in   1   one-cycle capture request for value
//     seg   out  70  digit i in seg[7*i+6:7*i], active-low, g..a
//     bcd   out  40  digit i in bcd[4*i+3:4*i], last completed conversion
//     busy  out  1   converter in SHIFT or COMMIT
//     done  out  1   one-cycle pulse when seg/bcd update
//   Build option: DISPLAY_BLANK_EN blanks leading zero digits.
// ----------------------------------------------------------------------------
module display_decoder
    import display_decoder_pkg::*;
#(
    parameter int WIDTH  = display_decoder_pkg::WIDTH,
    parameter int DIGITS = display_decoder_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    output logic [7*DIGITS-1:0]   seg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

`ifdef DISPLAY_BLANK_EN
    localparam logic [7*DIGITS-1:0] SEG_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_0};
`else
    localparam logic [7*DIGITS-1:0] SEG_RESET = {DIGITS{SEG_0}};
`endif

    state_t                state, next_state;
    logic [WIDTH-1:0]      shreg;
    logic [WIDTH-1:0]      pend_buf;
    logic                  pend_valid;
    logic [4*DIGITS-1:0]   acc;
    logic [4*DIGITS-1:0]   acc_adj;
    logic [CNT_W-1:0]      cnt;
    logic [7*DIGITS-1:0]   seg_raw;
    logic [7*DIGITS-1:0]   seg_next;

    // ---------------- state machine ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pend_valid)        next_state = SHIFT;
            SHIFT:   if (cnt == LAST_STEP)  next_state = COMMIT;
            COMMIT:                         next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ---------------- request buffer ----------------
    // Every load lands here; IDLE starts a conversion from the buffer on the
    // following edge. A load in the same cycle the buffer is consumed keeps
    // the flag set, so the newer word queues behind the one being started.
    // NOTE: the buffer is an ordinary register and is cleared on reset so a
    // stale word can never be replayed after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_buf   <= '0;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_buf   <= value;
            pend_valid <= 1'b1;
        end else if (state == IDLE && pend_valid) begin
            pend_valid <= 1'b0;
        end
    end

    // ---------------- double-dabble engine ----------------
    // Each nibble is corrected independently; 4-bit wrap is intended since a
    // corrected nibble (<= 12) never needs a carry into its neighbour.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        shreg <= pend_buf;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // {acc, shreg} << 1 after correction; acc's top bit is
                    // always zero for a 32-bit input in ten digits.
                    {acc, shreg} <= {acc_adj[4*DIGITS-2:0], shreg, 1'b0};
                    cnt          <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- display path ----------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .digit   (acc[4*g +: 4]),
            .pattern (seg_raw[7*g +: 7])
        );
    end

`ifdef DISPLAY_BLANK_EN
    // Walk down from the top digit; blank while still inside the leading
    // zeros. Digit 0 is never blanked so zero still reads "0".
    always_comb begin
        logic leading;
        seg_next = seg_raw;
        leading  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (acc[4*i +: 4] != 4'd0) leading = 1'b0;
            if (leading) seg_next[7*i +: 7] = SEG_BLANK;
        end
    end
`else
    assign seg_next = seg_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            seg  <= SEG_RESET;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            if (state == COMMIT) begin
                bcd <= acc;
                seg <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_display_decoder.sv
// ----------------------------------------------------------------------------
// tb_display_decoder
//   Self-checking bench for display_decoder. Expected digits come from plain
//   decimal arithmetic (repeated divide by ten); segment images come from a
//   digit-to-pattern table plus a magnitude test for leading-zero blanking.
//   Build option: DISPLAY_BLANK_EN (must match the RTL build).
// ----------------------------------------------------------------------------
module tb_display_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        load;
    logic [69:0] seg;
    logic [39:0] bcd;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_decoder dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .seg   (seg),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    // ---------------- reference model ----------------
    function automatic logic [39:0] model_bcd(input logic [31:0] v);
        logic [39:0]    r;
        longint unsigned x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [69:0] model_seg(input logic [31:0] v);
        logic [6:0]      pat [10];
        logic [69:0]     r;
        longint unsigned x;
        longint unsigned p;
        pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        x = longint'(v);
        p = 1;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[7*i +: 7] = pat[int'(x % 10)];
`ifdef DISPLAY_BLANK_EN
            if (i > 0 && longint'(v) < p) r[7*i +: 7] = 7'h7F;
`endif
            x = x / 10;
            p = p * 10;
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a word for one edge; returns #1 after the sampling edge.
    task automatic do_load(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
    endtask

    // Edges until done is seen, or -1 after the budget runs out.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_one(input logic [31:0] v, input string tag);
        int lat;
        do_load(v);
        wait_done(lat);
        check({tag, " latency"}, 70'(lat), 70'd34);
        check({tag, " bcd"}, 70'(bcd), 70'(model_bcd(v)));
        check({tag, " seg"}, seg, model_seg(v));
        check({tag, " busy after done"}, 70'(busy), 70'd0);
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, 70'(done), 70'd0);
    endtask

    typedef struct {
        logic [31:0] value;
        logic [39:0] bcd;
    } vec_t;

    logic [69:0] seg_reset_exp;

    initial begin
        vec_t vecs [6];
        int   first, second, extra, dones, busy_hi;
        logic [39:0] b1, b2;

        vecs[0] = '{32'd1234,       40'h0000001234};
        vecs[1] = '{32'hFFFF_FFFF,  40'h4294967295};
        vecs[2] = '{32'd0,          40'h0000000000};
        vecs[3] = '{32'd1000005,    40'h0001000005};
        vecs[4] = '{32'd9,          40'h0000000009};
        vecs[5] = '{32'd1000000000, 40'h1000000000};

`ifdef DISPLAY_BLANK_EN
        seg_reset_exp = {{9{7'h7F}}, 7'h40};
`else
        seg_reset_exp = {10{7'h40}};
`endif

        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset seg",  seg, seg_reset_exp);
        check("reset bcd",  70'(bcd), 70'd0);
        check("reset busy", 70'(busy), 70'd0);
        check("reset done", 70'(done), 70'd0);

        // Table: fixed words with hand-written BCD images.
        for (int i = 0; i < 6; i++) begin
            int lat;
            do_load(vecs[i].value);
            check($sformatf("vec%0d busy", i), 70'(busy), 70'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d busy started", i), 70'(busy), 70'd1);
            wait_done(lat);
            check($sformatf("vec%0d latency", i), 70'(lat + 1), 70'd34);
            check($sformatf("vec%0d bcd", i), 70'(bcd), 70'(vecs[i].bcd));
            check($sformatf("vec%0d seg", i), seg, model_seg(vecs[i].value));
            @(posedge clk);
            #1;
        end

        // Pending buffer: 42 then 99 arrive mid-conversion of 7; latest wins.
        do_load(32'd7);
        first  = -1;
        second = -1;
        extra  = 0;
        b1     = '0;
        b2     = '0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 10) begin
                value = 32'd42;
                load  = 1'b1;
            end else if (c == 20) begin
                value = 32'd99;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                if (first < 0)       begin first  = c; b1 = bcd; end
                else if (second < 0) begin second = c; b2 = bcd; end
                else                 extra++;
            end
        end
        load = 1'b0;
        check("pend first done time",  70'(first),  70'd34);
        check("pend first bcd",        70'(b1),     70'(model_bcd(32'd7)));
        check("pend second done time", 70'(second), 70'd68);
        check("pend second bcd",       70'(b2),     70'(model_bcd(32'd99)));
        check("pend extra dones",      70'(extra),  70'd0);
        check("pend final seg",        seg,         model_seg(32'd99));

        // Reset at cycle 15 of converting 500, with a coincident load.
        do_load(32'd500);
        repeat (14) @(posedge clk);
        #1;
        rst   = 1'b1;
        load  = 1'b1;
        value = 32'd77;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        load = 1'b0;
        check("rst seg",  seg, seg_reset_exp);
        check("rst bcd",  70'(bcd), 70'd0);
        check("rst busy", 70'(busy), 70'd0);
        check("rst done", 70'(done), 70'd0);
        dones   = 0;
        busy_hi = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (busy) busy_hi++;
        end
        check("rst no done",        70'(dones),   70'd0);
        check("rst load dropped",   70'(busy_hi), 70'd0);
        run_one(32'd8, "after rst");

        // Randomized words against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] v;
            v = (i % 2 == 0) ? $urandom() : 32'($urandom_range(0, 99999));
            run_one(v, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
